// File: rtl/serial_link_pkg.sv
// Types and constants shared by the serial link blocks (transmitter and receiver sides).
package serial_link_pkg;

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    localparam logic MSB_FIRST = 1'b0;
    localparam logic LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_assembler.sv
// Shift register and bit counter that assemble serial bits into words. It pulses
// `complete` together with the finished word, which includes the bit arriving this cycle.
module serial_word_assembler
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_in,
    input  logic             shift_left,
    input  logic             shift_right,
    output logic [WIDTH-1:0] word,
    output logic             complete,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_q, r_d;
    logic [CW-1:0]    count_q, count_d;
    logic             strobe;
    logic             dir;

    assign strobe = shift_left | shift_right;
    // shift_left has priority when both strobes are high
    assign dir    = shift_left ? MSB_FIRST : LSB_FIRST;

    always_comb begin
        r_d      = r_q;
        count_d  = count_q;
        complete = 1'b0;
        if (strobe) begin
            if (dir == MSB_FIRST) r_d = {r_q[WIDTH-2:0], shift_in};
            else                  r_d = {shift_in, r_q[WIDTH-1:1]};
            if (count_q == CW'(WIDTH-1)) begin
                count_d  = '0;
                complete = 1'b1;
            end else begin
                count_d  = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_q     <= '0;
            count_q <= '0;
        end else begin
            r_q     <= r_d;
            count_q <= count_d;
        end
    end

    assign word  = r_d;
    assign count = count_q;

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver. Assembled words go into a one-deep holding buffer
// with a valid/ready handshake, and a sticky overrun flag is set when a word is dropped.
module serial_word_receiver
    import serial_link_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH+1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             shift_in,
    input  logic             shift_left,
    input  logic             shift_right,
    input  logic             ready,
    output logic [WIDTH-1:0] q,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic [CW-1:0]    count
);

    buf_state_t       state_q;
    logic [WIDTH-1:0] q_q;
    logic             ovr_q;
    logic [WIDTH-1:0] word;
    logic             complete;

    serial_word_assembler #(.WIDTH(WIDTH), .CW(CW)) u_asm (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .shift_in    (shift_in),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .word        (word),
        .complete    (complete),
        .count       (count)
    );

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            state_q <= BUF_EMPTY;
            q_q     <= '0;
            ovr_q   <= 1'b0;
        end else begin
            case (state_q)
                BUF_EMPTY: begin
                    if (complete) begin
                        q_q     <= word;
                        state_q <= BUF_FULL;
                    end
                end
                BUF_FULL: begin
                    // An accept and a completion on the same edge hand over with no gap.
                    if (complete) begin
                        if (ready) q_q   <= word;
                        else       ovr_q <= 1'b1;
                    end else if (ready) begin
                        state_q <= BUF_EMPTY;
                    end
                end
                default: state_q <= BUF_EMPTY;
            endcase
        end
    end

    assign q       = q_q;
    assign valid   = (state_q == BUF_FULL);
    assign overrun = ovr_q;
    assign busy    = (count != '0);

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed test of serial_word_receiver at WIDTH=4 with hand-computed expectations.
module tb_serial_word_receiver;

    logic       clock = 1'b0;
    logic       reset, clear, shift_in, shift_left, shift_right, ready;
    logic [3:0] q;
    logic       valid, busy, overrun;
    logic [2:0] count;

    int total = 0;
    int bad   = 0;

    serial_word_receiver #(.WIDTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .shift_in    (shift_in),
        .shift_left  (shift_left),
        .shift_right (shift_right),
        .ready       (ready),
        .q           (q),
        .valid       (valid),
        .busy        (busy),
        .overrun     (overrun),
        .count       (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input logic b, input logic l, input logic r);
        shift_in    = b;
        shift_left  = l;
        shift_right = r;
        step();
        shift_left  = 1'b0;
        shift_right = 1'b0;
    endtask

    // Bits go out as w[3], w[2], w[1], w[0].
    task automatic send_l(input logic [3:0] w);
        for (int i = 3; i >= 0; i--) strobe(w[i], 1'b1, 1'b0);
    endtask

    initial begin
        logic [3:0] v;
        reset = 1'b1; clear = 1'b0; shift_in = 1'b0;
        shift_left = 1'b0; shift_right = 1'b0; ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_q", q, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_count", count, 0);

        // MSB-first 1,0,1,1
        ready = 1'b1;
        strobe(1, 1, 0); chk("msb_cnt1", count, 1);
        strobe(0, 1, 0); chk("msb_cnt2", count, 2);
        strobe(1, 1, 0); chk("msb_cnt3", count, 3);
        chk("msb_valid_early", valid, 0);
        strobe(1, 1, 0); chk("msb_cnt0", count, 0);
        chk("msb_q", q, 4'b1011);
        chk("msb_valid", valid, 1);
        step();
        chk("msb_valid_drop", valid, 0);

        // LSB-first 1,0,1,1
        v = 4'b1011;
        for (int i = 3; i >= 0; i--) begin
            strobe(v[i], 0, 1);
            chk("lsb_busy", busy, (i != 0));
        end
        chk("lsb_q", q, 4'b1101);
        chk("lsb_valid", valid, 1);
        step();

        // Backpressure: A then 5 with ready low
        ready = 1'b0;
        send_l(4'hA);
        chk("bp_q1", q, 4'hA);
        chk("bp_ovr1", overrun, 0);
        send_l(4'h5);
        chk("bp_q2", q, 4'hA);
        chk("bp_valid", valid, 1);
        chk("bp_ovr2", overrun, 1);
        ready = 1'b1; step(); ready = 1'b0;
        chk("bp_drain", valid, 0);
        chk("bp_ovr_sticky", overrun, 1);
        step();
        chk("bp_ovr_sticky2", overrun, 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("bp_ovr_clear", overrun, 0);

        // Accept and complete on the same edge
        send_l(4'h3);
        chk("sim_q3", q, 4'h3);
        chk("sim_v3", valid, 1);
        strobe(1, 1, 0); strobe(1, 1, 0); strobe(0, 1, 0);
        chk("sim_hold", q, 4'h3);
        ready = 1'b1;
        strobe(0, 1, 0);
        chk("sim_q", q, 4'hC);
        chk("sim_valid", valid, 1);
        chk("sim_ovr", overrun, 0);
        step();
        chk("sim_drain", valid, 0);

        // Clear mid-word
        strobe(1, 1, 0); strobe(1, 1, 0);
        chk("clr_busy_pre", busy, 1);
        clear = 1'b1; step(); clear = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_busy", busy, 0);
        chk("clr_valid", valid, 0);
        send_l(4'h6);
        chk("clr_q", q, 4'h6);
        chk("clr_valid2", valid, 1);

        // Both strobes high: shift_left behaviour
        v = 4'hC;
        for (int i = 3; i >= 0; i--) strobe(v[i], 1, 1);
        chk("both_q", q, 4'hC);
        step();

        // Reset with the completing strobe
        strobe(1, 1, 0); strobe(0, 1, 0); strobe(1, 1, 0);
        reset = 1'b1;
        strobe(1, 1, 0);
        reset = 1'b0;
        chk("rs_q", q, 0);
        chk("rs_valid", valid, 0);
        chk("rs_busy", busy, 0);
        chk("rs_ovr", overrun, 0);
        chk("rs_count", count, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
